iob_split: RTL and testbench

Address-decoding splitter for the iob native bus: one master port fans out to N_SLAVES slave ports. It sits on the master side of a shared peripheral region and steers each request to the slave selected by a field of the request address. It returns the selected slave's response to the master and tracks the single outstanding transaction. It generates its own error response when the decoded slave does not exist, or when the selected slave fails to answer within a timeout.

---
 rtl/iob_split.sv | 144 ++++++++++++++
 tb/tb_iob_split.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_split.sv
// iob native bus splitter: one master fans out to N_SLAVES slaves by address field,
// tracking a single outstanding transaction with decode-error and timeout responses.
module iob_split #(
   parameter int N_SLAVES = 2,
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 32,
   parameter int P_SLAVES = ADDR_W - 2,
   parameter int TIMEOUT  = 255,
   localparam int REQ_W   = 1 + ADDR_W + DATA_W + DATA_W / 8,
   localparam int RESP_W  = DATA_W + 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [REQ_W-1:0]           m_req,
   output logic [RESP_W-1:0]          m_resp,
   output logic [N_SLAVES*REQ_W-1:0]  s_req,
   input  logic [N_SLAVES*RESP_W-1:0] s_resp,
   output logic                       err,
   output logic [1:0]                 err_type
);

   // state | meaning
   // IDLE  | no transaction outstanding, accepting requests
   // BUSY  | request forwarded to slave sel_reg, waiting for its ready
   // DERR  | returning the decode-error response, accepting a new request

   localparam int NB     = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
   localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam int SEL_HI = DATA_W + DATA_W / 8 + P_SLAVES;
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   typedef enum logic [1:0] {IDLE, BUSY, DERR} state_t;

   state_t             state, state_nxt;
   logic [NB-1:0]      sel_reg;
   logic [CNT_W-1:0]   cnt;
   logic [1:0]         err_type_q;

   logic               m_valid;
   logic [NB-1:0]      sel_in;
   logic               sel_ok;
   logic [RESP_W-1:0]  sel_resp;
   logic               sel_ready;
   logic               can_accept;
   logic               accept;
   logic               to_derr;
   logic               timeout_hit;
   logic               violation;
   logic [1:0]         err_cause;

   assign m_valid = m_req[REQ_W-1];
   assign sel_in  = m_req[SEL_HI -: NB];
   assign sel_ok  = (32'(sel_in) < 32'(N_SLAVES));

   always_comb begin
      sel_resp = '0;
      for (int k = 0; k < N_SLAVES; k++) begin
         if (sel_reg == NB'(k)) sel_resp = s_resp[k*RESP_W +: RESP_W];
      end
   end

   assign sel_ready   = (state == BUSY) && sel_resp[0];
   assign can_accept  = (state == IDLE) || (state == DERR) || sel_ready;
   assign accept      = m_valid && can_accept && sel_ok;
   assign to_derr     = m_valid && can_accept && !sel_ok;
   assign timeout_hit = (TIMEOUT > 0) && (state == BUSY) && !sel_ready && (cnt == TO_LAST);
   // a timeout takes priority over a coincident violating valid; both drop the request
   assign violation   = (state == BUSY) && m_valid && !sel_ready && !timeout_hit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         sel_reg    <= '0;
         cnt        <= '0;
         err_type_q <= 2'd0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            sel_reg <= sel_in;
            cnt     <= '0;
         end else if ((state == BUSY) && !sel_ready && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_W'(1);
         end
         if (err) err_type_q <= err_cause;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DERR: begin
            if (accept)       state_nxt = BUSY;
            else if (to_derr) state_nxt = DERR;
            else              state_nxt = IDLE;
         end
         BUSY: begin
            if (sel_ready) begin
               if (accept)       state_nxt = BUSY;
               else if (to_derr) state_nxt = DERR;
               else              state_nxt = IDLE;
            end else if (timeout_hit) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      s_req     = '0;
      m_resp    = '0;
      err       = 1'b0;
      err_cause = 2'd0;
      // reset gates the combinational request path so nothing leaks while rst_n is low
      for (int k = 0; k < N_SLAVES; k++) begin
         if (rst_n && accept && (sel_in == NB'(k))) s_req[k*REQ_W +: REQ_W] = m_req;
      end
      case (state)
         BUSY: begin
            if (timeout_hit) begin
               m_resp    = {{DATA_W{1'b1}}, 1'b1};
               err       = 1'b1;
               err_cause = 2'd2;
            end else begin
               m_resp = sel_resp;
               if (violation) begin
                  err       = 1'b1;
                  err_cause = 2'd3;
               end
            end
         end
         DERR: begin
            m_resp    = {{DATA_W{1'b0}}, 1'b1};
            err       = 1'b1;
            err_cause = 2'd1;
         end
         default: ;
      endcase
   end

   assign err_type = err ? err_cause : err_type_q;

endmodule

// File: tb/tb_iob_split.sv
// Directed bench for iob_split: 3 slaves selected by addr[31:30], TIMEOUT=8,
// expected master responses queued at stimulus time and checked as they appear.
module tb_iob_split;

   localparam int NS     = 3;
   localparam int REQ_W  = 1 + 32 + 32 + 4;
   localparam int RESP_W = 33;

   logic                     clk;
   logic                     rst_n;
   logic [REQ_W-1:0]         m_req;
   logic [RESP_W-1:0]        m_resp;
   logic [NS*REQ_W-1:0]      s_req;
   logic [NS*RESP_W-1:0]     s_resp;
   logic                     err;
   logic [1:0]               err_type;

   iob_split #(
      .N_SLAVES(NS), .DATA_W(32), .ADDR_W(32), .P_SLAVES(31), .TIMEOUT(8)
   ) dut (
      .clk(clk), .rst_n(rst_n), .m_req(m_req), .m_resp(m_resp),
      .s_req(s_req), .s_resp(s_resp), .err(err), .err_type(err_type)
   );

   typedef struct {
      logic [32:0] resp;
      logic        err;
      logic [1:0]  et;
      int          cyc;
   } exp_t;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   int   t0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [REQ_W-1:0] mk_req(input logic [31:0] a, input logic [31:0] d);
      return {1'b1, a, d, 4'hF};
   endfunction

   function automatic logic [REQ_W-1:0] slot(input int k);
      return s_req[k*REQ_W +: REQ_W];
   endfunction

   task automatic sresp(input int k, input logic [31:0] d);
      s_resp[k*RESP_W +: RESP_W] = {d, 1'b1};
   endtask

   task automatic push(input logic [32:0] r, input logic e, input logic [1:0] et, input int c);
      exp_t x;
      x.resp = r; x.err = e; x.et = et; x.cyc = c;
      q.push_back(x);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      m_req  = '0;
      s_resp = '0;
   endtask

   task automatic settle();
      #3;
   endtask

   // scoreboard: every ready seen on the master side must match the head of the queue
   always @(negedge clk) begin
      if (rst_n && m_resp[0]) begin
         if (q.size() == 0) begin
            chk("unexpected_ready", {95'd0, m_resp}, 128'd0);
         end else begin
            exp_t x;
            x = q.pop_front();
            chk("resp_data", {95'd0, m_resp}, {95'd0, x.resp});
            chk("resp_cycle", 128'(cyc), 128'(x.cyc));
            chk("resp_err", {127'd0, err}, {127'd0, x.err});
            chk("resp_err_type", {126'd0, err_type}, {126'd0, x.et});
         end
      end
   end

   initial begin
      rst_n  = 1'b0;
      m_req  = mk_req(32'h4000_0010, 32'h0);
      s_resp = '0;
      settle();
      chk("rst_m_resp", {95'd0, m_resp}, 128'd0);
      chk("rst_s_req", 128'(s_req), 128'd0);
      chk("rst_err", {127'd0, err}, 128'd0);
      chk("rst_err_type", {126'd0, err_type}, 128'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // basic read through slave 1, stray ready from slave 0 ignored
      tick();
      m_req = mk_req(32'h4000_0010, 32'h0000_A5A5);
      t0 = cyc;
      push({32'h1234, 1'b1}, 1'b0, 2'd0, t0 + 3);
      settle();
      chk("fwd_slot1", 128'(slot(1)), 128'(mk_req(32'h4000_0010, 32'h0000_A5A5)));
      chk("fwd_slot0_zero", 128'(slot(0)), 128'd0);
      chk("fwd_slot2_zero", 128'(slot(2)), 128'd0);
      chk("fwd_no_resp", {95'd0, m_resp}, 128'd0);
      tick();
      settle();
      chk("busy_s_req_zero", 128'(s_req), 128'd0);
      tick();
      sresp(0, 32'hDEAD_0000);
      settle();
      chk("other_ready_ignored", {95'd0, m_resp}, 128'd0);
      tick();
      sresp(1, 32'h1234);
      settle();
      chk("basic_no_err", {127'd0, err}, 128'd0);

      // back-to-back: slave 0 ready with a new valid to slave 2
      tick();
      m_req = mk_req(32'h0000_0004, 32'h1);
      push({32'h1111, 1'b1}, 1'b0, 2'd0, cyc + 2);
      tick();
      tick();
      sresp(0, 32'h1111);
      m_req = mk_req(32'h8000_0000, 32'h2);
      push({32'h2222, 1'b1}, 1'b0, 2'd0, cyc + 1);
      settle();
      chk("b2b_fwd_slot2", 128'(slot(2)), 128'(mk_req(32'h8000_0000, 32'h2)));
      chk("b2b_slot0_zero", 128'(slot(0)), 128'd0);
      tick();
      sresp(2, 32'h2222);
      tick();

      // decode error, with a new request accepted in the DERR cycle
      tick();
      m_req = mk_req(32'hC000_0000, 32'h3);
      push({32'h0, 1'b1}, 1'b1, 2'd1, cyc + 1);
      settle();
      chk("derr_no_fwd", 128'(s_req), 128'd0);
      chk("derr_err_late", {127'd0, err}, 128'd0);
      tick();
      m_req = mk_req(32'h8000_0100, 32'h4);
      push({32'h3333, 1'b1}, 1'b0, 2'd1, cyc + 2);
      settle();
      chk("derr_err", {127'd0, err}, 128'd1);
      chk("derr_err_type", {126'd0, err_type}, 128'd1);
      chk("derr_accept_slot2", 128'(slot(2)), 128'(mk_req(32'h8000_0100, 32'h4)));
      tick();
      settle();
      chk("derr_err_clear", {127'd0, err}, 128'd0);
      chk("derr_type_held", {126'd0, err_type}, 128'd1);
      tick();
      sresp(2, 32'h3333);
      tick();

      // timeout: slave 1 never answers, late ready discarded
      tick();
      m_req = mk_req(32'h4000_0000, 32'h5);
      t0 = cyc;
      push({32'hFFFF_FFFF, 1'b1}, 1'b1, 2'd2, t0 + 8);
      for (int i = 1; i < 8; i++) begin
         tick();
         settle();
         chk("to_waiting", {95'd0, m_resp}, 128'd0);
      end
      tick();
      settle();
      chk("to_err", {127'd0, err}, 128'd1);
      chk("to_err_type", {126'd0, err_type}, 128'd2);
      tick();
      tick();
      sresp(1, 32'h5555);
      settle();
      chk("to_late_ready_dropped", {95'd0, m_resp}, 128'd0);
      tick();

      // protocol violation: second valid while BUSY
      tick();
      m_req = mk_req(32'h0000_0000, 32'h6);
      push({32'h7777, 1'b1}, 1'b0, 2'd3, cyc + 3);
      tick();
      m_req = mk_req(32'h4000_0000, 32'h7);
      settle();
      chk("viol_no_fwd", 128'(s_req), 128'd0);
      chk("viol_err", {127'd0, err}, 128'd1);
      chk("viol_err_type", {126'd0, err_type}, 128'd3);
      tick();
      settle();
      chk("viol_err_clear", {127'd0, err}, 128'd0);
      tick();
      sresp(0, 32'h7777);
      tick();

      // reset mid-BUSY
      tick();
      m_req = mk_req(32'h8000_0000, 32'h8);
      tick();
      tick();
      rst_n = 1'b0;
      m_req = mk_req(32'h4000_0000, 32'h9);
      sresp(2, 32'hBAD0);
      settle();
      chk("midrst_m_resp", {95'd0, m_resp}, 128'd0);
      chk("midrst_s_req", 128'(s_req), 128'd0);
      chk("midrst_err", {127'd0, err}, 128'd0);
      chk("midrst_err_type", {126'd0, err_type}, 128'd0);
      tick();
      rst_n = 1'b1;
      tick();
      sresp(2, 32'hBAD1);
      settle();
      chk("stale_ready_ignored", {95'd0, m_resp}, 128'd0);
      tick();
      m_req = mk_req(32'h0000_0008, 32'hA);
      push({32'h8888, 1'b1}, 1'b0, 2'd0, cyc + 1);
      settle();
      chk("post_rst_fwd", 128'(slot(0)), 128'(mk_req(32'h0000_0008, 32'hA)));
      tick();
      sresp(0, 32'h8888);
      tick();
      tick();

      chk("queue_drained", 128'(q.size()), 128'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
